// File: rtl/alu_op_sequencer.sv
// Request FIFO plus a three-state issue FSM that feeds an external combinational ALU,
// captures each result and hands it downstream over a valid/ready interface.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_en,
  input  logic [15:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [3:0]  res_cmd,
  output logic        res_err,
  output logic        busy,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_e;

  localparam logic [3:0]     CMD_DIV  = 4'b0101;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [7:0]         alu_a_q, alu_a_d;
  logic [7:0]         alu_b_q, alu_b_d;
  logic [3:0]         alu_cmd_q, alu_cmd_d;
  logic               alu_en_q, alu_en_d;
  logic               res_valid_q, res_valid_d;
  logic [15:0]        res_data_q, res_data_d;
  logic [3:0]         res_cmd_q, res_cmd_d;
  logic               res_err_q, res_err_d;
  logic [15:0]        op_count_q, op_count_d;

  logic [19:0]        mem_q [DEPTH];
  logic               full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;

  // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cmd_d   = alu_cmd_q;
    alu_en_d    = alu_en_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_cmd_d   = res_cmd_q;
    res_err_d   = res_err_q;
    op_count_d  = op_count_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop                            = 1'b1;
          {alu_cmd_d, alu_a_d, alu_b_d}  = mem_q[rd_ptr_q];
          alu_en_d                       = 1'b1;
          state_d                        = ISSUE;
        end
      end
      ISSUE: begin
        res_data_d  = alu_out;
        res_cmd_d   = alu_cmd_q;
        res_err_d   = (alu_cmd_q == CMD_DIV) && (alu_b_q == 8'd0);
        res_valid_d = 1'b1;
        alu_en_d    = 1'b0;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          op_count_d  = op_count_q + 16'd1;
          res_valid_d = 1'b0;
          if (!empty) begin
            // Chain straight into the next request to sustain one result every two cycles.
            pop                           = 1'b1;
            {alu_cmd_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q];
            alu_en_d                      = 1'b1;
            state_d                       = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cmd_q   <= '0;
      alu_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cmd_q   <= '0;
      res_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_en_q    <= alu_en_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cmd_q   <= res_cmd_d;
      res_err_q   <= res_err_d;
      op_count_q  <= op_count_d;
    end
  end

  // NOTE: storage is not reset; the occupancy counter alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {in_cmd, in_a, in_b};
  end

  assign in_ready  = !full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cmd   = alu_cmd_q;
  assign alu_en    = alu_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_cmd   = res_cmd_q;
  assign res_err   = res_err_q;
  assign op_count  = op_count_q;
  assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on the alu_* side.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_cmd;
  logic        res_err;
  logic        busy;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_en(alu_en), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cmd(res_cmd),
    .res_err(res_err), .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // ADD=0, SUB=1, MUL=2, DIV=5 (divide by zero yields all ones).
  always_comb begin
    alu_out = 16'h0000;
    case (alu_cmd)
      4'h0: alu_out = 16'(alu_a) + 16'(alu_b);
      4'h1: alu_out = 16'(alu_a) - 16'(alu_b);
      4'h2: alu_out = 16'(alu_a) * 16'(alu_b);
      4'h5: alu_out = (alu_b == 8'd0) ? 16'hFFFF : 16'(alu_a / alu_b);
      default: alu_out = 16'h0000;
    endcase
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    in_cmd   = c;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic test_reset();
    reset = 1'b1; res_ready = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    repeat (2) tick();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
    n_checks++; if ({alu_en, alu_cmd, alu_a, alu_b} !== 21'h0) begin n_fail++; $display("FAIL rst_alu: got %h want 0", {alu_en, alu_cmd, alu_a, alu_b}); end
    n_checks++; if ({res_data, res_cmd, res_err} !== 21'h0) begin n_fail++; $display("FAIL rst_res: got %h want 0", {res_data, res_cmd, res_err}); end
    n_checks++; if (op_count !== 16'h0) begin n_fail++; $display("FAIL rst_op_count: got %h want 0", op_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_add();
    res_ready = 1'b1;
    drive(1'b1, 4'h0, 8'd25, 8'd17);
    tick();                                   // E0: push
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    n_checks++; if ({res_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL add_e0: got valid/busy %b want 01", {res_valid, busy}); end
    tick();                                   // E1: pop into ALU regs
    n_checks++; if ({alu_en, alu_cmd, alu_a, alu_b} !== {1'b1, 4'h0, 8'd25, 8'd17}) begin n_fail++; $display("FAIL add_e1_alu: got %h want %h", {alu_en, alu_cmd, alu_a, alu_b}, {1'b1, 4'h0, 8'd25, 8'd17}); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_e1_valid: got %b want 0", res_valid); end
    tick();                                   // E2: capture
    n_checks++; if ({res_valid, res_data, res_cmd, res_err} !== {1'b1, 16'h002A, 4'h0, 1'b0}) begin n_fail++; $display("FAIL add_e2_result: got %h want %h", {res_valid, res_data, res_cmd, res_err}, {1'b1, 16'h002A, 4'h0, 1'b0}); end
    n_checks++; if (alu_en !== 1'b0) begin n_fail++; $display("FAIL add_e2_alu_en: got %b want 0", alu_en); end
    tick();                                   // E3: handshake
    n_checks++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL add_op_count: got %0d want 1", op_count); end
    n_checks++; if ({res_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL add_idle: got valid/busy %b want 00", {res_valid, busy}); end
    n_checks++; if ({alu_cmd, alu_a, alu_b} !== {4'h0, 8'd25, 8'd17}) begin n_fail++; $display("FAIL add_alu_hold: got %h want %h", {alu_cmd, alu_a, alu_b}, {4'h0, 8'd25, 8'd17}); end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    drive(1'b1, 4'h1, 8'd20, 8'd10);
    tick();                                   // E0
    drive(1'b1, 4'h0, 8'd20, 8'd10);
    tick();                                   // E1
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_e1_valid: got %b want 0", res_valid); end
    tick();                                   // E2
    n_checks++; if ({res_valid, res_data, res_cmd} !== {1'b1, 16'h000A, 4'h1}) begin n_fail++; $display("FAIL b2b_first: got %h want %h", {res_valid, res_data, res_cmd}, {1'b1, 16'h000A, 4'h1}); end
    tick();                                   // E3
    n_checks++; if ({res_valid, alu_en} !== 2'b01) begin n_fail++; $display("FAIL b2b_e3: got valid/alu_en %b want 01", {res_valid, alu_en}); end
    tick();                                   // E4
    n_checks++; if ({res_valid, res_data, res_cmd} !== {1'b1, 16'h001E, 4'h0}) begin n_fail++; $display("FAIL b2b_second: got %h want %h", {res_valid, res_data, res_cmd}, {1'b1, 16'h001E, 4'h0}); end
    tick();                                   // E5
    n_checks++; if ({op_count, busy} !== {16'd3, 1'b0}) begin n_fail++; $display("FAIL b2b_end: got op_count/busy %h want %h", {op_count, busy}, {16'd3, 1'b0}); end
  endtask

  task automatic test_full();
    logic [3:0]  cmds [5] = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h1};
    logic [7:0]  as   [5] = '{8'd1, 8'd9, 8'd3, 8'd200, 8'd5};
    logic [7:0]  bs   [5] = '{8'd2, 8'd4, 8'd7, 8'd100, 8'd9};
    logic [15:0] exps [5] = '{16'h0003, 16'h0005, 16'h0015, 16'h012C, 16'hFFFC};
    int got;
    int extra;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_push%0d: got %b want 1", i, in_ready); end
      drive(1'b1, cmds[i], as[i], bs[i]);
      tick();
    end
    drive(1'b1, 4'h0, 8'h77, 8'h11);          // sixth request must be refused
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    repeat (2) tick();
    n_checks++; if ({in_ready, res_valid, res_data} !== {1'b0, 1'b1, 16'h0003}) begin n_fail++; $display("FAIL full_hold: got %h want %h", {in_ready, res_valid, res_data}, {1'b0, 1'b1, 16'h0003}); end
    res_ready = 1'b1;
    n_checks++; if (res_data !== exps[0]) begin n_fail++; $display("FAIL full_res0: got %h want %h", res_data, exps[0]); end
    got = 1;
    tick();                                   // pop while full: blocked push must not slip in
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_no_push: in_ready got %b want 1", in_ready); end
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (res_valid) begin
        n_checks++; if ({res_data, res_cmd} !== {exps[got], cmds[got]}) begin n_fail++; $display("FAIL full_res%0d: got %h want %h", got, {res_data, res_cmd}, {exps[got], cmds[got]}); end
        got++;
      end
      tick();
    end
    n_checks++; if (got !== 5) begin n_fail++; $display("FAIL full_count_results: got %0d want 5", got); end
    n_checks++; if (op_count !== 16'd8) begin n_fail++; $display("FAIL full_op_count: got %0d want 8", op_count); end
    extra = 0;
    repeat (4) begin
      if (res_valid) extra++;
      tick();
    end
    n_checks++; if ({extra, busy} !== {32'd0, 1'b0}) begin n_fail++; $display("FAIL full_no_extra: got extra=%0d busy=%b want 0/0", extra, busy); end
  endtask

  task automatic test_div();
    logic [15:0] exps [2] = '{16'hFFFF, 16'h0005};
    logic        errs [2] = '{1'b1, 1'b0};
    int got = 0;
    res_ready = 1'b1;
    drive(1'b1, 4'h5, 8'd40, 8'd0);
    tick();
    drive(1'b1, 4'h5, 8'd40, 8'd8);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (res_valid) begin
        n_checks++; if ({res_data, res_cmd, res_err} !== {exps[got], 4'h5, errs[got]}) begin n_fail++; $display("FAIL div_res%0d: got %h want %h", got, {res_data, res_cmd, res_err}, {exps[got], 4'h5, errs[got]}); end
        got++;
      end
      tick();
    end
    n_checks++; if ({got, op_count, busy} !== {32'd2, 16'd10, 1'b0}) begin n_fail++; $display("FAIL div_end: got results=%0d op_count=%0d busy=%b want 2/10/0", got, op_count, busy); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 8'(i + 1), 8'd1);
      tick();
    end
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    n_checks++; if ({res_valid, busy} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got valid/busy %b want 11", {res_valid, busy}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({in_ready, busy, res_valid} !== 3'b100) begin n_fail++; $display("FAIL mid_flags: got ready/busy/valid %b want 100", {in_ready, busy, res_valid}); end
    n_checks++; if ({alu_en, alu_cmd, alu_a, alu_b, res_data, res_cmd, res_err, op_count} !== 58'h0) begin n_fail++; $display("FAIL mid_regs: got %h want 0", {alu_en, alu_cmd, alu_a, alu_b, res_data, res_cmd, res_err, op_count}); end
    res_ready = 1'b1;
    repeat (8) begin
      tick();
      if (res_valid || alu_en) seen++;
    end
    n_checks++; if ({seen, op_count} !== {32'd0, 16'd0}) begin n_fail++; $display("FAIL mid_stale: got activity=%0d op_count=%0d want 0/0", seen, op_count); end
  endtask

  task automatic test_wrap();
    logic [15:0] exps [2] = '{16'h0007, 16'h000B};
    logic [15:0] cnts [2] = '{16'hFFFF, 16'h0000};
    int got = 0;
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    n_checks++; if (op_count !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload: got %h want fffe", op_count); end
    res_ready = 1'b1;
    drive(1'b1, 4'h0, 8'd3, 8'd4);
    tick();
    drive(1'b1, 4'h0, 8'd5, 8'd6);
    tick();
    drive(1'b0, 4'h0, 8'h00, 8'h00);
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (res_valid) begin
        n_checks++; if (res_data !== exps[got]) begin n_fail++; $display("FAIL wrap_res%0d: got %h want %h", got, res_data, exps[got]); end
        tick();
        n_checks++; if (op_count !== cnts[got]) begin n_fail++; $display("FAIL wrap_cnt%0d: got %h want %h", got, op_count, cnts[got]); end
        got++;
      end else begin
        tick();
      end
    end
    n_checks++; if ({got, busy, res_valid} !== {32'd2, 1'b0, 1'b0}) begin n_fail++; $display("FAIL wrap_end: got results=%0d busy=%b valid=%b want 2/0/0", got, busy, res_valid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_full();
    test_div();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
